// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the sequential Booth multiplier.
//   - mul_state_t : multiplier FSM states (IDLE -> RUN -> DONE -> IDLE)
//   - MUL_DATA_WIDTH : default operand width
//   - MUL_STEPS   : Booth steps per multiply (operand width + 1 extension bit)
//   - MUL_CNT_W   : width of the step counter able to hold 0..MUL_STEPS
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  localparam int MUL_DATA_WIDTH = 32;
  localparam int MUL_STEPS      = MUL_DATA_WIDTH + 1;
  localparam int MUL_CNT_W      = $clog2(MUL_STEPS + 1);

endpackage : cpu_pkg

// File: rtl/booth_seq_multiplier_step.sv
// ---------------------------------------------------------------------------
// booth_step
//   One combinational radix-2 Booth step on an N-bit datapath.
//   {q_i[0], q_m1_i} selects: 01 -> A+M, 10 -> A-M, 00/11 -> A (all mod 2^N),
//   then {A,Q,Q_-1} is shifted right arithmetically by one bit.
// Ports
//   a_i, q_i, q_m1_i, m_i : current accumulator, multiplier, Q_-1, multiplicand
//   a_o, q_o, q_m1_o      : next accumulator, multiplier, Q_-1
// ---------------------------------------------------------------------------
module booth_step #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] q_i,
  input  logic         q_m1_i,
  input  logic [N-1:0] m_i,
  output logic [N-1:0] a_o,
  output logic [N-1:0] q_o,
  output logic         q_m1_o
);

  logic [N-1:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], q_m1_i})
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
  end

  // Arithmetic shift of the concatenation {sum, q, q_m1}: the sign bit of
  // the accumulator is replicated, the accumulator LSB moves into Q.
  assign a_o    = {sum[N-1], sum[N-1:1]};
  assign q_o    = {sum[0], q_i[N-1:1]};
  assign q_m1_o = q_i[0];

endmodule : booth_step

// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
//   Sequential radix-2 Booth multiplier producing a 2*DATA_WIDTH product for
//   the HI/LO registers. One Booth step per clock on a DATA_WIDTH+1 bit
//   datapath so the same hardware covers signed and unsigned operands.
//
// Optional feature macro: MUL_UNSIGNED_EN
//   defined   : adds input mul_unsigned (1 = zero-extend operands, 0 = sign-extend)
//   undefined : operands are always sign-extended
//
// Ports
//   clock        in  rising-edge clock
//   clear        in  asynchronous active-high reset; aborts any multiply
//   start        in  multiply request, sampled only while idle
//   mul_unsigned in  (MUL_UNSIGNED_EN only) operand extension select
//   multiplicand in  operand M, captured on the accepting edge
//   multiplier   in  operand Q, captured on the accepting edge
//   busy         out high while running and during the done cycle
//   done         out one-cycle pulse; hi_out/lo_out valid from this cycle
//   hi_out       out product upper half, held until next completion
//   lo_out       out product lower half, held until next completion
//
// Handshake: start is accepted on a rising edge where the FSM is idle; it is
// ignored while busy is high. Exactly one done pulse follows each accepted
// start, DATA_WIDTH+1 edges after acceptance, unless clear intervenes.
// ---------------------------------------------------------------------------
module booth_seq_multiplier
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = MUL_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
`ifdef MUL_UNSIGNED_EN
  input  logic                  mul_unsigned,
`endif
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int N  = DATA_WIDTH + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  mul_state_t            state_q;
  logic [N-1:0]          a_q, q_q, m_q;
  logic                  qm1_q;
  logic [CW-1:0]         count_q;
  logic                  busy_q, done_q;
  logic [DATA_WIDTH-1:0] hi_q, lo_q;

  logic [N-1:0]          a_d, q_d;
  logic                  qm1_d;
  logic                  ext_m, ext_q;

`ifdef MUL_UNSIGNED_EN
  assign ext_m = mul_unsigned ? 1'b0 : multiplicand[DATA_WIDTH-1];
  assign ext_q = mul_unsigned ? 1'b0 : multiplier[DATA_WIDTH-1];
`else
  assign ext_m = multiplicand[DATA_WIDTH-1];
  assign ext_q = multiplier[DATA_WIDTH-1];
`endif

  booth_step #(.N(N)) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .q_m1_i (qm1_q),
    .m_i    (m_q),
    .a_o    (a_d),
    .q_o    (q_d),
    .q_m1_o (qm1_d)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            m_q     <= {ext_m, multiplicand};
            q_q     <= {ext_q, multiplier};
            a_q     <= '0;
            qm1_q   <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          a_q     <= a_d;
          q_q     <= q_d;
          qm1_q   <= qm1_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_CNT) begin
            // {A,Q} is 2N bits; the product is its low 2*DATA_WIDTH bits.
            hi_q    <= {a_d[DATA_WIDTH-2:0], q_d[DATA_WIDTH]};
            lo_q    <= q_d[DATA_WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= MUL_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= MUL_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule : booth_seq_multiplier
